mem_stage_dataok: RTL and testbench

//  Memory stage, directly downstream of the EXE stage. Latches the EXE-to-MEM bus and waits for the

---
 rtl/mem_stage_dataok.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage_dataok.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dataok.sv
// mem_stage_dataok -- memory stage of the pipeline, directly after EXE.
//
// Latches the EXE-to-MEM bus, waits for the data_ok response of every load or
// store that EXE issued for the entry, extracts and extends load data, and
// forwards the result to WB and the register-forwarding path in ID.
// Responses belonging to requests flushed by an exception or ertn are counted
// and dropped when they eventually arrive.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   EXE_to_MEM_BUS/valid incoming instruction from EXE
//   MEM_allowin          MEM can accept an instruction this cycle
//   data_sram_data_ok    one response per issued request, with data_sram_rdata
//   WB_allowin           WB can accept
//   MEM_to_WB_valid/BUS  instruction handed to WB
//   MEM_RF_BUS           forwarding / hazard information for ID
//   ertn_flush, wb_ex    pipeline flushes raised in WB
//   mem_ex, mem_ertn     valid exception / ertn currently held in MEM
//
// Build option: define MEM_EARLY_LOAD_FWD_EN to forward load data from MEM in
// the data_ok cycle (load_pending drops as soon as the stage is ready to go).

`ifndef EXE_to_MEM_LEN
`define EXE_to_MEM_LEN 198
`endif
`ifndef MEM_to_WB_LEN
`define MEM_to_WB_LEN 190
`endif
`ifndef MEM_RF_LEN
`define MEM_RF_LEN 55
`endif

module mem_stage_dataok #(
    parameter int DISCARD_W = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [`EXE_to_MEM_LEN-1:0] EXE_to_MEM_BUS,
    input  logic                       EXE_to_MEM_valid,
    output logic                       MEM_allowin,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       WB_allowin,
    output logic                       MEM_to_WB_valid,
    output logic [`MEM_to_WB_LEN-1:0]  MEM_to_WB_BUS,
    output logic [`MEM_RF_LEN-1:0]     MEM_RF_BUS,
    input  logic                       ertn_flush,
    input  logic                       wb_ex,
    output logic                       mem_ex,
    output logic                       mem_ertn
);

    // Selects and extends the addressed byte/half of a load word.
    // load_op is one-hot: [0]LD_B [1]LD_H [2]LD_W [3]LD_BU [4]LD_HU.
    function automatic logic [31:0] load_extend(input logic [4:0]  op,
                                                input logic [1:0]  a,
                                                input logic [31:0] raw);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (a)
            2'd0:    byte_v = raw[7:0];
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = raw[7:0];
        endcase
        half_v = a[1] ? raw[31:16] : raw[15:0];
        if (op[0]) begin
            res_v = {{24{byte_v[7]}}, byte_v};
        end else if (op[1]) begin
            res_v = {{16{half_v[15]}}, half_v};
        end else if (op[3]) begin
            res_v = {24'd0, byte_v};
        end else if (op[4]) begin
            res_v = {16'd0, half_v};
        end else begin
            res_v = raw;
        end
        return res_v;
    endfunction

    localparam logic [DISCARD_W-1:0] DISCARD_MAX  = {DISCARD_W{1'b1}};
    localparam logic [DISCARD_W-1:0] DISCARD_ZERO = {DISCARD_W{1'b0}};
    localparam logic [DISCARD_W-1:0] DISCARD_ONE  = {{(DISCARD_W-1){1'b0}}, 1'b1};

    logic                       mem_valid_r;
    logic [`EXE_to_MEM_LEN-1:0] bus_r;
    logic                       data_got_r;
    logic [31:0]                rdata_buf_r;
    logic [DISCARD_W-1:0]       discard_cnt_r;

    // Fields of the latched bus
    logic [31:0] pc_s;
    logic        gr_we_s;
    logic [4:0]  dest_s;
    logic [31:0] exe_result_s;
    logic        mem_sum_unused_s;
    logic        mem_en_s;
    logic [4:0]  load_op_s;
    logic        rfrom_mem_s;
    logic [13:0] csr_num_s;
    logic        csr_we_s;
    logic [31:0] csr_wvalue_s;
    logic [31:0] csr_wmask_s;
    logic        ex_s;
    logic [5:0]  ex_code_s;
    logic [31:0] ex_vaddr_s;
    logic        inst_ertn_s;
    logic        rfrom_cntid_s;

    assign {pc_s, gr_we_s, dest_s, exe_result_s, mem_sum_unused_s, mem_en_s,
            load_op_s, rfrom_mem_s, csr_num_s, csr_we_s, csr_wvalue_s,
            csr_wmask_s, ex_s, ex_code_s, ex_vaddr_s, inst_ertn_s,
            rfrom_cntid_s} = bus_r;

    logic        need_data_s;
    logic        discard_zero_s;
    logic        ready_go_s;
    logic        flush_s;
    logic        accept_s;
    logic        load_pending_s;
    logic [31:0] raw_s;
    logic [31:0] final_result_s;

    // An excepting access never reached the bus, so it has no response to wait for.
    assign need_data_s     = (rfrom_mem_s | mem_en_s) & ~ex_s;
    assign discard_zero_s  = (discard_cnt_r == DISCARD_ZERO);
    // A response arriving while stale responses are outstanding belongs to a flushed request.
    assign ready_go_s      = ~need_data_s | data_got_r | (data_sram_data_ok & discard_zero_s);
    assign MEM_allowin     = ~mem_valid_r | (ready_go_s & WB_allowin);
    assign MEM_to_WB_valid = mem_valid_r & ready_go_s;
    assign flush_s         = wb_ex | ertn_flush;
    assign accept_s        = EXE_to_MEM_valid & MEM_allowin;

    assign raw_s          = data_got_r ? rdata_buf_r : data_sram_rdata;
    assign final_result_s = rfrom_mem_s ? load_extend(load_op_s, exe_result_s[1:0], raw_s)
                                        : exe_result_s;

`ifdef MEM_EARLY_LOAD_FWD_EN
    assign load_pending_s = mem_valid_r & rfrom_mem_s & ~ready_go_s;
`else
    assign load_pending_s = mem_valid_r & rfrom_mem_s;
`endif

    assign mem_ex   = mem_valid_r & ex_s;
    assign mem_ertn = mem_valid_r & inst_ertn_s;

    assign MEM_to_WB_BUS = {pc_s, gr_we_s, dest_s, final_result_s, csr_num_s,
                            csr_we_s, csr_wvalue_s, csr_wmask_s, ex_s,
                            ex_code_s, ex_vaddr_s, inst_ertn_s, rfrom_cntid_s};

    assign MEM_RF_BUS = {dest_s & {5{gr_we_s & mem_valid_r}}, load_pending_s,
                         final_result_s, mem_valid_r, csr_we_s, csr_num_s,
                         rfrom_cntid_s};

    // Stage valid bit: flush wins over accepting a new instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_r <= 1'b0;
        end else if (flush_s) begin
            mem_valid_r <= 1'b0;
        end else if (MEM_allowin) begin
            mem_valid_r <= EXE_to_MEM_valid;
        end else begin
            mem_valid_r <= mem_valid_r;
        end
    end

    // EXE-to-MEM bus register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r <= {`EXE_to_MEM_LEN{1'b0}};
        end else if (accept_s) begin
            bus_r <= EXE_to_MEM_BUS;
        end else begin
            bus_r <= bus_r;
        end
    end

    // Response buffer: holds data that arrived while WB could not take the instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_got_r  <= 1'b0;
            rdata_buf_r <= 32'd0;
        end else if (accept_s) begin
            data_got_r  <= 1'b0;
            rdata_buf_r <= 32'd0;
        end else if (data_sram_data_ok && discard_zero_s && mem_valid_r && need_data_s &&
                     !data_got_r && !(MEM_to_WB_valid && WB_allowin)) begin
            data_got_r  <= 1'b1;
            rdata_buf_r <= data_sram_rdata;
        end else begin
            data_got_r  <= data_got_r;
            rdata_buf_r <= rdata_buf_r;
        end
    end

    // Count of responses still owed to flushed requests; each one is dropped on arrival.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt_r <= DISCARD_ZERO;
        end else if (data_sram_data_ok && !discard_zero_s) begin
            discard_cnt_r <= discard_cnt_r - DISCARD_ONE;
        end else if (flush_s && mem_valid_r && need_data_s && !data_got_r &&
                     !data_sram_data_ok && (discard_cnt_r != DISCARD_MAX)) begin
            discard_cnt_r <= discard_cnt_r + DISCARD_ONE;
        end else begin
            discard_cnt_r <= discard_cnt_r;
        end
    end

endmodule

// File: tb/tb_mem_stage_dataok.sv
// Directed bench for mem_stage_dataok: load wait, extension, buffering under
// WB back-pressure, flushed-response dropping, exceptions, ertn, store, and
// asynchronous reset in the middle of a wait.
module tb_mem_stage_dataok;

    localparam int E2M_W = 198;
    localparam int M2W_W = 190;
    localparam int RF_W  = 55;

    logic             clk;
    logic             resetn;
    logic [E2M_W-1:0] EXE_to_MEM_BUS;
    logic             EXE_to_MEM_valid;
    logic             MEM_allowin;
    logic             data_sram_data_ok;
    logic [31:0]      data_sram_rdata;
    logic             WB_allowin;
    logic             MEM_to_WB_valid;
    logic [M2W_W-1:0] MEM_to_WB_BUS;
    logic [RF_W-1:0]  MEM_RF_BUS;
    logic             ertn_flush;
    logic             wb_ex;
    logic             mem_ex;
    logic             mem_ertn;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_dataok dut (
        .clk               (clk),
        .resetn            (resetn),
        .EXE_to_MEM_BUS    (EXE_to_MEM_BUS),
        .EXE_to_MEM_valid  (EXE_to_MEM_valid),
        .MEM_allowin       (MEM_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .WB_allowin        (WB_allowin),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .MEM_to_WB_BUS     (MEM_to_WB_BUS),
        .MEM_RF_BUS        (MEM_RF_BUS),
        .ertn_flush        (ertn_flush),
        .wb_ex             (wb_ex),
        .mem_ex            (mem_ex),
        .mem_ertn          (mem_ertn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bus fields
    logic [31:0] wb_final;
    logic        wb_gr_we;
    logic        wbbus_ex;
    logic [4:0]  rf_dest;
    logic        rf_load_pending;
    logic [31:0] rf_final;
    logic        rf_valid;
    assign wb_final        = MEM_to_WB_BUS[151:120];
    assign wb_gr_we        = MEM_to_WB_BUS[157];
    assign wbbus_ex        = MEM_to_WB_BUS[40];
    assign rf_dest         = MEM_RF_BUS[54:50];
    assign rf_load_pending = MEM_RF_BUS[49];
    assign rf_final        = MEM_RF_BUS[48:17];
    assign rf_valid        = MEM_RF_BUS[16];

`ifdef MEM_EARLY_LOAD_FWD_EN
    localparam logic LP_AT_DATA_OK = 1'b0;
`else
    localparam logic LP_AT_DATA_OK = 1'b1;
`endif

    function automatic logic [E2M_W-1:0] mk_bus(input logic [31:0] pc,
                                                input logic        gr_we,
                                                input logic [4:0]  dest,
                                                input logic [31:0] res,
                                                input logic        mem_en,
                                                input logic [4:0]  lop,
                                                input logic        rfm,
                                                input logic        ex,
                                                input logic [5:0]  ecode,
                                                input logic        ertn);
        return {pc, gr_we, dest, res, 1'b0, mem_en, lop, rfm, 14'd0, 1'b0,
                32'd0, 32'd0, ex, ecode, res, ertn, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetn            = 1'b0;
        EXE_to_MEM_BUS    = '0;
        EXE_to_MEM_valid  = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        WB_allowin        = 1'b1;
        ertn_flush        = 1'b0;
        wb_ex             = 1'b0;

        // Reset state, before any clock edge
        #1;
        chk("rst_allowin", {31'd0, MEM_allowin}, 32'd1);
        chk("rst_to_wb_valid", {31'd0, MEM_to_WB_valid}, 32'd0);
        chk("rst_mem_ex", {31'd0, mem_ex}, 32'd0);
        chk("rst_mem_ertn", {31'd0, mem_ertn}, 32'd0);
        chk("rst_rf_dest", {27'd0, rf_dest}, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // ld.w 0x1000, data_ok after 3 waiting cycles
        EXE_to_MEM_BUS   = mk_bus(32'h1c000000, 1'b1, 5'd5, 32'h00001000, 1'b1, 5'b00100, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        #1;
        chk("ldw_accept_allowin", {31'd0, MEM_allowin}, 32'd1);
        tick();
        EXE_to_MEM_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldw_wait_allowin", {31'd0, MEM_allowin}, 32'd0);
            chk("ldw_wait_valid", {31'd0, MEM_to_WB_valid}, 32'd0);
            chk("ldw_wait_pending", {31'd0, rf_load_pending}, 32'd1);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        #1;
        chk("ldw_done_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("ldw_done_result", wb_final, 32'hDEADBEEF);
        chk("ldw_done_allowin", {31'd0, MEM_allowin}, 32'd1);
        chk("ldw_rf_dest", {27'd0, rf_dest}, 32'd5);
        chk("ldw_rf_final", rf_final, 32'hDEADBEEF);
        chk("ldw_done_pending", {31'd0, rf_load_pending}, {31'd0, LP_AT_DATA_OK});
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldw_after_valid", {31'd0, MEM_to_WB_valid}, 32'd0);

        // ld.b addr ...2
        EXE_to_MEM_BUS   = mk_bus(32'h1c000004, 1'b1, 5'd6, 32'h00001002, 1'b1, 5'b00001, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid  = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h00800000;
        #1;
        chk("ldb_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("ldb_result", wb_final, 32'hFFFFFF80);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.hu addr ...2
        EXE_to_MEM_BUS   = mk_bus(32'h1c000008, 1'b1, 5'd6, 32'h00001002, 1'b1, 5'b10000, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid  = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80010000;
        #1;
        chk("ldhu_result", wb_final, 32'h00008001);
        tick();
        data_sram_data_ok = 1'b0;

        // data_ok while WB stalls: response buffered, later bus data ignored
        EXE_to_MEM_BUS   = mk_bus(32'h1c00000c, 1'b1, 5'd7, 32'h00002000, 1'b1, 5'b00100, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid  = 1'b0;
        WB_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h12345678;
        #1;
        chk("buf_dok_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("buf_dok_allowin", {31'd0, MEM_allowin}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hAAAAAAAA;
        #1;
        chk("buf_hold_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("buf_hold_result", wb_final, 32'h12345678);
        tick();
        WB_allowin = 1'b1;
        #1;
        chk("buf_release_result", wb_final, 32'h12345678);
        chk("buf_release_allowin", {31'd0, MEM_allowin}, 32'd1);
        tick();

        // wb_ex while a load waits: its response is dropped, the next load completes
        EXE_to_MEM_BUS   = mk_bus(32'h1c000010, 1'b1, 5'd8, 32'h00003000, 1'b1, 5'b00100, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid = 1'b0;
        wb_ex            = 1'b1;
        tick();
        wb_ex = 1'b0;
        #1;
        chk("flush_valid_cleared", {31'd0, rf_valid}, 32'd0);
        chk("flush_allowin", {31'd0, MEM_allowin}, 32'd1);
        EXE_to_MEM_BUS   = mk_bus(32'h1c000014, 1'b1, 5'd9, 32'h00004000, 1'b1, 5'b00100, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid  = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0BAD0;
        #1;
        chk("drop_valid", {31'd0, MEM_to_WB_valid}, 32'd0);
        chk("drop_allowin", {31'd0, MEM_allowin}, 32'd0);
        tick();
        data_sram_rdata = 32'h0C0FFEE0;
        #1;
        chk("after_drop_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("after_drop_result", wb_final, 32'h0C0FFEE0);
        tick();
        data_sram_data_ok = 1'b0;

        // Excepting ld.w (ALE): ready immediately, no response awaited
        EXE_to_MEM_BUS   = mk_bus(32'h1c000018, 1'b1, 5'd10, 32'h00005001, 1'b1, 5'b00100, 1'b1, 1'b1, 6'h09, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid = 1'b0;
        #1;
        chk("exc_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("exc_mem_ex", {31'd0, mem_ex}, 32'd1);
        chk("exc_bus_ex", {31'd0, wbbus_ex}, 32'd1);
        chk("exc_allowin", {31'd0, MEM_allowin}, 32'd1);
        tick();
        #1;
        chk("exc_gone_mem_ex", {31'd0, mem_ex}, 32'd0);

        // ertn passes straight through
        EXE_to_MEM_BUS   = mk_bus(32'h1c00001c, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'b00000, 1'b0, 1'b0, 6'd0, 1'b1);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid = 1'b0;
        #1;
        chk("ertn_mem_ertn", {31'd0, mem_ertn}, 32'd1);
        chk("ertn_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        tick();

        // st.w waits for data_ok; result is the address, gr_we stays 0
        EXE_to_MEM_BUS   = mk_bus(32'h1c000020, 1'b0, 5'd0, 32'h00005000, 1'b1, 5'b00000, 1'b0, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid = 1'b0;
        #1;
        chk("st_wait_valid", {31'd0, MEM_to_WB_valid}, 32'd0);
        chk("st_wait_pending", {31'd0, rf_load_pending}, 32'd0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFFFFFF;
        #1;
        chk("st_done_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("st_done_result", wb_final, 32'h00005000);
        chk("st_done_gr_we", {31'd0, wb_gr_we}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;

        // Async reset during a wait with a stale response outstanding
        EXE_to_MEM_BUS   = mk_bus(32'h1c000024, 1'b1, 5'd11, 32'h00006000, 1'b1, 5'b00100, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid = 1'b0;
        wb_ex            = 1'b1;
        tick();
        wb_ex            = 1'b0;
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid = 1'b0;
        #1;
        chk("arst_pre_allowin", {31'd0, MEM_allowin}, 32'd0);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_allowin", {31'd0, MEM_allowin}, 32'd1);
        chk("arst_valid", {31'd0, rf_valid}, 32'd0);
        chk("arst_to_wb_valid", {31'd0, MEM_to_WB_valid}, 32'd0);
        #1;
        resetn = 1'b1;
        tick();
        EXE_to_MEM_BUS   = mk_bus(32'h1c000028, 1'b1, 5'd12, 32'h00007000, 1'b1, 5'b00100, 1'b1, 1'b0, 6'd0, 1'b0);
        EXE_to_MEM_valid = 1'b1;
        tick();
        EXE_to_MEM_valid  = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h600DF00D;
        #1;
        chk("arst_next_valid", {31'd0, MEM_to_WB_valid}, 32'd1);
        chk("arst_next_result", wb_final, 32'h600DF00D);
        tick();
        data_sram_data_ok = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
